// File: rtl/gbm_step_engine.sv
// Geometric-Brownian-motion step engine.
// Prices for NUM_PATHS Monte-Carlo paths are advanced one step per normal
// sample. Samples arrive step-major: sample k updates path k % NUM_PATHS
// for step k / NUM_PATHS. The price update runs through a three-stage
// pipeline that holds completely still while the output is back-pressured.

package fpga_cfg_pkg;
  parameter int FP_WIDTH = 32;
  parameter int FP_QINT  = 15;
  parameter int FP_QFRAC = 16;
endpackage

module gbm_step_engine #(
  parameter int WIDTH     = fpga_cfg_pkg::FP_WIDTH,
  parameter int QINT      = fpga_cfg_pkg::FP_QINT,
  parameter int QFRAC     = fpga_cfg_pkg::FP_QFRAC,
  parameter int NUM_PATHS = 8,
  parameter int NUM_STEPS = 16,
  localparam int PW = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] s0,
  input  logic [WIDTH-1:0] drift,
  input  logic [WIDTH-1:0] sigma,
  input  logic             sqrt_valid,
  input  logic [WIDTH-1:0] sqrt_in,
  input  logic             z_valid,
  output logic             z_ready,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_price,
  output logic [PW-1:0]    out_path,
  output logic [SW-1:0]    out_step,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int TOTAL = NUM_PATHS * NUM_STEPS;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_C   = CW'(TOTAL - 1);
  localparam logic [PW-1:0] PATH_MAX = PW'(NUM_PATHS - 1);

  // Saturation bounds and ONE, all sign-extended to product width.
  localparam logic signed [2*WIDTH-1:0] MAX_X = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MIN_X = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] ONE_X = {{(2*WIDTH-1){1'b0}}, 1'b1} <<< QFRAC;

  // The pipeline is only hazard-free when a path is revisited no sooner
  // than the write-back of its previous step, and the Q format must fill
  // the word exactly.
  if (NUM_PATHS < 4 || (QINT + QFRAC + 1) != WIDTH) begin : g_bad_cfg
    $error("gbm_step_engine: illegal parameter combination");
  end

  // Sign-extend a word to product width.
  function automatic logic signed [2*WIDTH-1:0] sext(input logic signed [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  // Clamp a wide value into the signed word range.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [2*WIDTH-1:0] x);
    logic signed [WIDTH-1:0] r;
    if (x > MAX_X) begin
      r = MAX_X[WIDTH-1:0];
    end else if (x < MIN_X) begin
      r = MIN_X[WIDTH-1:0];
    end else begin
      r = x[WIDTH-1:0];
    end
    return r;
  endfunction

  // Prices cannot go negative: floor them at zero.
  function automatic logic signed [WIDTH-1:0] floor_zero(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] r;
    if (x[WIDTH-1]) begin
      r = '0;
    end else begin
      r = x;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VOL = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t state;

  logic signed [WIDTH-1:0] drift_r;
  logic signed [WIDTH-1:0] sigma_r;
  logic signed [WIDTH-1:0] volstep_r;
  logic signed [WIDTH-1:0] price_r [NUM_PATHS];

  logic [CW-1:0] acc_cnt_r;
  logic [PW-1:0] path_r;
  logic [SW-1:0] step_r;

  // Stage 1 registers
  logic                    v1_r;
  logic [PW-1:0]           path1_r;
  logic [SW-1:0]           step1_r;
  logic                    last1_r;
  logic signed [WIDTH-1:0] price1_r;
  logic signed [WIDTH-1:0] t1_r;

  // Stage 2 registers
  logic                      v2_r;
  logic [PW-1:0]             path2_r;
  logic [SW-1:0]             step2_r;
  logic                      last2_r;
  logic signed [2*WIDTH-1:0] p2_r;

  logic stall_s;
  logic accept_s;
  logic load_s;

  logic signed [2*WIDTH-1:0] vol_prod_s;
  logic signed [WIDTH-1:0]   vol_s;
  logic signed [2*WIDTH-1:0] t_prod_s;
  logic signed [WIDTH-1:0]   t_s;
  logic signed [2*WIDTH-1:0] f_sum_s;
  logic signed [WIDTH-1:0]   f_s;
  logic signed [2*WIDTH-1:0] p_prod_s;
  logic signed [2*WIDTH-1:0] p_s;
  logic signed [WIDTH-1:0]   wb_s;

  assign stall_s  = out_valid && !out_ready;
  assign z_ready  = (state == ST_RUN) && !stall_s && (acc_cnt_r < TOTAL_C);
  assign accept_s = z_valid && z_ready;
  assign load_s   = (state == ST_IDLE) && start;

  // Fixed-point arithmetic for volstep, the stage-1 shock and stage-2 growth.
  always_comb begin
    vol_prod_s = sext(sigma_r) * sext(sqrt_in);
    vol_s      = sat_w(vol_prod_s >>> QFRAC);
    t_prod_s   = sext(volstep_r) * sext(z_in);
    t_s        = sat_w(t_prod_s >>> QFRAC);
    f_sum_s    = ONE_X + sext(drift_r) + sext(t1_r);
    f_s        = sat_w(f_sum_s);
    p_prod_s   = sext(price1_r) * sext(f_s);
    p_s        = p_prod_s >>> QFRAC;
    wb_s       = floor_zero(sat_w(p2_r));
  end

  // Run-control FSM with registered busy/done and the latched run parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drift_r   <= '0;
      sigma_r   <= '0;
      volstep_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            drift_r <= drift;
            sigma_r <= sigma;
            busy    <= 1'b1;
            state   <= ST_WAIT_VOL;
          end
        end
        ST_WAIT_VOL: begin
          if (sqrt_valid) begin
            volstep_r <= vol_s;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s && (acc_cnt_r == LAST_C)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample counters, price store and the three pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PATHS; i++) begin
        price_r[i] <= '0;
      end
      acc_cnt_r <= '0;
      path_r    <= '0;
      step_r    <= '0;
      v1_r      <= 1'b0;
      path1_r   <= '0;
      step1_r   <= '0;
      last1_r   <= 1'b0;
      price1_r  <= '0;
      t1_r      <= '0;
      v2_r      <= 1'b0;
      path2_r   <= '0;
      step2_r   <= '0;
      last2_r   <= 1'b0;
      p2_r      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_price <= '0;
      out_path  <= '0;
      out_step  <= '0;
    end else begin
      if (load_s) begin
        for (int i = 0; i < NUM_PATHS; i++) begin
          price_r[i] <= s0;
        end
        acc_cnt_r <= '0;
        path_r    <= '0;
        step_r    <= '0;
      end else if (accept_s) begin
        acc_cnt_r <= acc_cnt_r + CW'(1);
        if (path_r == PATH_MAX) begin
          path_r <= '0;
          step_r <= step_r + SW'(1);
        end else begin
          path_r <= path_r + PW'(1);
        end
      end

      if (!stall_s) begin
        // S1: fetch the path's current price and form the scaled shock.
        v1_r <= accept_s;
        if (accept_s) begin
          path1_r  <= path_r;
          step1_r  <= step_r;
          last1_r  <= (acc_cnt_r == LAST_C);
          price1_r <= price_r[path_r];
          t1_r     <= t_s;
        end
        // S2: growth factor and raw new price.
        v2_r <= v1_r;
        if (v1_r) begin
          path2_r <= path1_r;
          step2_r <= step1_r;
          last2_r <= last1_r;
          p2_r    <= p_s;
        end
        // S3: saturate, floor, write back and present.
        out_valid <= v2_r;
        out_last  <= v2_r && last2_r;
        if (v2_r) begin
          price_r[path2_r] <= wb_s;
          out_price        <= wb_s;
          out_path         <= path2_r;
          out_step         <= step2_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_gbm_step_engine.sv
// Randomized bench for gbm_step_engine with a plain-arithmetic price model.
module tb_gbm_step_engine;

  localparam int NP    = 4;
  localparam int NS    = 2;
  localparam int TOTAL = NP * NS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] s0 = '0;
  logic [31:0] drift = '0;
  logic [31:0] sigma = '0;
  logic        sqrt_valid = 1'b0;
  logic [31:0] sqrt_in = '0;
  logic        z_valid = 1'b0;
  logic        z_ready;
  logic [31:0] z_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_price;
  logic [1:0]  out_path;
  logic        out_step;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  gbm_step_engine #(
    .WIDTH(32), .QINT(15), .QFRAC(16), .NUM_PATHS(NP), .NUM_STEPS(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s0(s0), .drift(drift),
    .sigma(sigma), .sqrt_valid(sqrt_valid), .sqrt_in(sqrt_in),
    .z_valid(z_valid), .z_ready(z_ready), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_price(out_price),
    .out_path(out_path), .out_step(out_step), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint price;
    int     path;
    int     step;
    bit     last;
    int     cyc;
  } exp_t;

  exp_t   expq[$];
  longint m_price[NP];
  longint m_vol;
  longint m_drift;
  int     acc_k;
  int     outs_seen;
  int     cyc = 0;
  bit     run_no_stall;
  bit     prev_stall = 1'b0;
  logic [31:0] prev_price;
  logic [1:0]  prev_path;
  logic        prev_step;
  longint obs_price[NP][NS];
  longint first_price;

  function automatic longint sat(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic longint sv(input logic [31:0] b);
    return longint'($signed(b));
  endfunction

  // Real-number view: new = old * (1 + drift + volstep*z), clamped, floored at 0.
  task automatic model_accept(input longint z);
    exp_t   e;
    longint t, f, p;
    int     path, step;
    path = acc_k % NP;
    step = acc_k / NP;
    t = sat((m_vol * z) >>> 16);
    f = sat(64'sd65536 + m_drift + t);
    p = sat((m_price[path] * f) >>> 16);
    if (p < 0) p = 0;
    m_price[path] = p;
    e.price = p;
    e.path  = path;
    e.step  = step;
    e.last  = (acc_k == TOTAL - 1);
    e.cyc   = cyc;
    expq.push_back(e);
    acc_k++;
  endtask

  // One cycle: inputs were set at the falling edge; observe 1 time unit later.
  task automatic tick();
    exp_t e;
    #1;
    if (prev_stall) begin
      chk("stall_hold_price", out_price, prev_price);
      chk("stall_hold_path", out_path, prev_path);
      chk("stall_hold_step", out_step, prev_step);
      chk("stall_hold_valid", out_valid, 1);
    end
    if (out_valid && !out_ready) chk("z_ready_in_stall", z_ready, 0);
    if (z_valid && z_ready) begin
      chk("over_accept", (acc_k < TOTAL), 1);
      model_accept(sv(z_in));
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        e = expq.pop_front();
        chk("out_price", sv(out_price), e.price);
        chk("out_path", out_path, e.path);
        chk("out_step", out_step, e.step);
        chk("out_last", out_last, e.last);
        if (run_no_stall) chk("latency", cyc - e.cyc, 3);
        if (outs_seen == 0) first_price = sv(out_price);
        obs_price[e.path][e.step] = sv(out_price);
        outs_seen++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_price = out_price;
    prev_path  = out_path;
    prev_step  = out_step;
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_z_ready"}, z_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_price"}, out_price, 0);
    chk({tag, "_out_path"}, out_path, 0);
    chk({tag, "_out_step"}, out_step, 0);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 held low 5 cycles mid-run.
  task automatic do_run(input longint s0v, input longint drv, input longint sgv,
                        input longint sqv, input int ready_mode, input bit force_z0,
                        input longint z0v, input bit junk, input int abort_at);
    int budget;
    int n;
    expq.delete();
    acc_k = 0;
    outs_seen = 0;
    run_no_stall = (ready_mode == 0);
    m_drift = drv;
    for (int i = 0; i < NP; i++) m_price[i] = s0v;
    s0    = s0v[31:0];
    drift = drv[31:0];
    sigma = sgv[31:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_wait_vol", busy, 1);
    chk("z_ready_wait_vol", z_ready, 0);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) tick();
    sqrt_in = sqv[31:0];
    sqrt_valid = 1'b1;
    tick();
    sqrt_valid = 1'b0;
    m_vol = sat((sgv * sqv) >>> 16);
    budget = 400;
    n = 0;
    while (outs_seen < TOTAL && budget > 0) begin
      if (abort_at != 0 && n == abort_at) begin
        z_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        prev_stall = 1'b0;
        break;
      end
      z_valid = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (force_z0 && acc_k == 0) begin
        z_in = z0v[31:0];
      end else if ($urandom_range(0, 9) == 0) begin
        z_in = 32'hFFEC_0000;
      end else begin
        z_in = 32'(longint'($urandom_range(0, 524288)) - 64'sd262144);
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(n >= 6 && n < 11);
      endcase
      if (junk) begin
        start      = ($urandom_range(0, 3) == 0);
        sqrt_valid = ($urandom_range(0, 3) == 0);
        sqrt_in    = $urandom;
      end
      tick();
      budget--;
      n++;
    end
    start = 1'b0;
    sqrt_valid = 1'b0;
    z_valid = 1'b0;
    out_ready = 1'b1;
    if (abort_at == 0) begin
      if (budget == 0) chk("run_timeout", outs_seen, TOTAL);
      chk("done_pulse", done, 1);
      chk("busy_after", busy, 0);
      chk("z_ready_after", z_ready, 0);
      tick();
      chk("done_single", done, 0);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // sqrt_valid while idle must not move the FSM.
    sqrt_in = 32'h0000_8000;
    sqrt_valid = 1'b1;
    tick();
    sqrt_valid = 1'b0;
    chk("idle_sqrt_busy", busy, 0);
    chk("idle_sqrt_z_ready", z_ready, 0);

    // 100.0, sigma 0.2, sqrt(dt) 0.5, z = 1.0 on path 0.
    do_run(64'sd100 <<< 16, 0, 13107, 32768, 0, 1'b1, 65536, 1'b0, 0);
    chk("case1_price", first_price, 7208900);

    // Continuous stream, always ready.
    do_run(64'sd50 <<< 16, 66, 19661, 16384, 0, 1'b0, 0, 1'b0, 0);

    // out_ready held low five cycles.
    do_run(64'sd80 <<< 16, -200, 26214, 40000, 2, 1'b0, 0, 1'b0, 0);

    // Large negative shock drives path 0 to zero; it stays there.
    do_run(64'sd100 <<< 16, 0, 13107, 32768, 0, 1'b1, -(64'sd20 <<< 16), 1'b0, 0);
    chk("case4_step0", obs_price[0][0], 0);
    chk("case4_step1", obs_price[0][1], 0);

    // Saturation at the top of the range.
    do_run(64'sd30000 <<< 16, 64'sd65536, 6554, 32768, 1, 1'b0, 0, 1'b1, 0);

    // Abort mid-run, nothing comes out afterwards, then a clean run.
    do_run(64'sd50 <<< 16, 66, 19661, 16384, 0, 1'b0, 0, 1'b0, 6);
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      tick();
      chk("post_abort_valid", out_valid, 0);
      chk("post_abort_busy", busy, 0);
    end
    do_run(64'sd50 <<< 16, 66, 19661, 16384, 0, 1'b0, 0, 1'b0, 0);

    // Randomized runs with back-pressure and ignored start/sqrt_valid.
    for (int r = 0; r < 20; r++) begin
      do_run(longint'($urandom_range(1, 200)) <<< 16,
             longint'($urandom_range(0, 2000)) - 64'sd1000,
             longint'($urandom_range(0, 65536)),
             longint'($urandom_range(0, 65536)),
             1, 1'b0, 0, 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gbm_step_engine.md
GBM_STEP_ENGINE -- requirements
Module: gbm_step_engine

Interface
REQ-001 SHALL have parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH, signed fixed-point word width.
REQ-002 SHALL have parameter QINT, default fpga_cfg_pkg::FP_QINT, integer bits.
REQ-003 SHALL have parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC, fraction bits; ONE = 1<<QFRAC.
REQ-004 SHALL have parameters NUM_PATHS, default 8, and NUM_STEPS, default 16; NUM_PATHS >= 4 is a legal-configuration requirement.
REQ-005 SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1, reset).
REQ-006 SHALL have start (in, 1, run request), s0 (in, WIDTH, initial price), drift (in, WIDTH, mu*dt), sigma (in, WIDTH, volatility).
REQ-007 SHALL have sqrt_valid (in, 1) and sqrt_in (in, WIDTH): sqrt(dt) from the upstream square-root unit; no backpressure.
REQ-008 SHALL have z_valid (in, 1), z_ready (out, 1), z_in (in, WIDTH): normal-sample stream.
REQ-009 SHALL have out_valid (out, 1), out_ready (in, 1), out_price (out, WIDTH), out_path (out, clog2(NUM_PATHS)), out_step (out, clog2(NUM_STEPS)), out_last (out, 1).
REQ-010 SHALL have busy (out, 1) and done (out, 1, single-cycle pulse).
REQ-011 One clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-012 States: IDLE, WAIT_VOL, RUN, DRAIN, DONE.
REQ-013 IDLE: on start, latch s0/drift/sigma, load all NUM_PATHS price registers with s0, and go to WAIT_VOL; start is ignored in every other state.
REQ-014 WAIT_VOL: on sqrt_valid, volstep = (sigma*sqrt_in)>>>QFRAC, saturated, then go to RUN; sqrt_valid is ignored in every other state.
REQ-015 Ordering is step-major: sample k maps to path = k mod NUM_PATHS and step = k div NUM_PATHS.
REQ-016 Transfer happens when z_valid && z_ready; z_ready = (state==RUN) && !stall && accepted < NUM_PATHS*NUM_STEPS.
REQ-017 Pipeline has 3 stages:
- S1: read price[path]; t = (volstep*z_in)>>>QFRAC.
- S2: f = ONE + drift + t, saturated; p = (price*f)>>>QFRAC.
- S3: saturate p to the signed range, floor negatives to 0, write back to price[path], register outputs.
REQ-018 Latency: a sample accepted at cycle t gives out_valid at t+3 when there is no stall.
REQ-019 Products are 2*WIDTH wide, arithmetically shifted (truncation toward minus infinity), and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 stall = out_valid && !out_ready; a stall freezes every stage, and out_* SHALL stay stable while stalled.
REQ-021 out_price/out_path/out_step carry the updated price; out_last is high only for the final sample (path NUM_PATHS-1, step NUM_STEPS-1).
REQ-022 After the last acceptance, RUN -> DRAIN; DRAIN -> DONE once the last output transfers; DONE pulses done for one cycle, then -> IDLE.
REQ-023 busy is high in WAIT_VOL, RUN, and DRAIN.
REQ-024 A price read in S1 SHALL see the write-back from the previous step; this is guaranteed by NUM_PATHS >= 4 > pipeline depth.
REQ-025 Price registers persist after DONE until the next start.

Reset
REQ-026 While rst_n is low, all outputs are 0 (z_ready, out_valid, out_last, busy, done, out_price, out_path, out_step), state is IDLE, counters and pipeline valids are 0, price registers are 0.
REQ-027 Reset asserted mid-RUN or mid-DRAIN aborts immediately; no out_valid appears after deassertion until a new start.

Verification
REQ-028 Case 1: WIDTH=32, QFRAC=16, s0=100.0, drift=0, sigma=0.2, sqrt_in=0.5, z=1.0 on path 0 -> out_price ~110.0 (within 4 LSB), out_path=0, out_step=0, 3 cycles after acceptance.
REQ-029 Case 2: NUM_PATHS=4, NUM_STEPS=2, continuous z, out_ready=1 -> 8 outputs, path sequence 0,1,2,3,0,1,2,3, out_last only on the 8th, done one cycle after it, busy low after.
REQ-030 Case 3: out_ready held low 5 cycles during RUN -> z_ready low, out_* frozen; on release, no sample is lost or duplicated.
REQ-031 Case 4: z=-20.0 with volstep=0.1 -> out_price=0; the next step for that path stays 0.
REQ-032 Case 5: start and sqrt_valid during RUN -> both ignored; sqrt_valid in IDLE -> no state change.
REQ-033 Case 6: rst_n low for 1 cycle mid-RUN -> all outputs 0 and state IDLE; a following full run matches the case 2 results.
